// File: rtl/cdc_frame_pkg.sv
// Purpose: shared definitions for the framed A->B channel (transmitter and deframer).
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Frame word 0 is the header: Len in [LEN_W-1:0], Seq in [SEQ_LSB +: SEQ_W], zeros above.
// The last word is the checksum, chosen so that all frame words sum to 0 mod 2^DATA_W.
package cdc_frame_pkg;

    localparam int DATA_W  = 32;
    localparam int MAX_LEN = 16;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int SEQ_W   = 8;
    localparam int SEQ_LSB = LEN_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_CHECKSUM
    } tx_state_e;

    function automatic logic [DATA_W-1:0] pack_header(input logic [LEN_W-1:0] len,
                                                      input logic [SEQ_W-1:0] seq);
        logic [DATA_W-1:0] h;
        h = '0;
        h[LEN_W-1:0]         = len;
        h[SEQ_LSB +: SEQ_W]  = seq;
        return h;
    endfunction

    // Returns 1 when the bits above the Seq field are zero, i.e. a well-formed header.
    function automatic logic unpack_header(input  logic [DATA_W-1:0] h,
                                           output logic [LEN_W-1:0]  len,
                                           output logic [SEQ_W-1:0]  seq);
        len = h[LEN_W-1:0];
        seq = h[SEQ_LSB +: SEQ_W];
        return (h[DATA_W-1:SEQ_LSB+SEQ_W] == '0);
    endfunction

    function automatic logic [DATA_W-1:0] checksum_word(input logic [DATA_W-1:0] sum);
        return '0 - sum;
    endfunction

endpackage

// File: rtl/cdc_frame_tx_if.sv
// Purpose: frame request, payload source and FIFO push signals of the domain-A transmitter.
// Latency: n/a (wiring only).
// Backpressure: FifoFull_DA stalls the push side; SrcReady_DA reflects it to the source.
//
// master: the transmitter (drives StartReady/SrcReady/Push/DataIn/FrameDone/LenError).
// slave : the environment (request source, payload source and FIFO write port).
interface cdc_frame_tx_if #(
    parameter int DataWidth = 32,
    parameter int LenW      = 5
);
    logic                 Start_DA;
    logic [LenW-1:0]      Len_DA;
    logic                 StartReady_DA;
    logic                 SrcValid_DA;
    logic [DataWidth-1:0] SrcData_DA;
    logic                 SrcReady_DA;
    logic                 Push_DA;
    logic [DataWidth-1:0] DataIn_DA;
    logic                 FifoFull_DA;
    logic                 FrameDone_DA;
    logic                 LenError_DA;

    modport master (
        input  Start_DA, Len_DA, SrcValid_DA, SrcData_DA, FifoFull_DA,
        output StartReady_DA, SrcReady_DA, Push_DA, DataIn_DA, FrameDone_DA, LenError_DA
    );

    modport slave (
        output Start_DA, Len_DA, SrcValid_DA, SrcData_DA, FifoFull_DA,
        input  StartReady_DA, SrcReady_DA, Push_DA, DataIn_DA, FrameDone_DA, LenError_DA
    );
endinterface

// File: rtl/cdc_frame_tx.sv
// Purpose: domain-A framer; pushes header, Len payload words and a zero-sum checksum word.
// Latency: header presented the cycle after Start is accepted; push path is combinational.
// Backpressure: FifoFull_DA holds state and push word; SrcReady_DA = !FifoFull_DA in PAYLOAD.
//
// Ports: clk_DA, rst (async active-high), bus (cdc_frame_tx_if.master): request
// Start/Len/StartReady, payload SrcValid/SrcData/SrcReady, FIFO Push/DataIn/FifoFull,
// pulses FrameDone/LenError.
module cdc_frame_tx
    import cdc_frame_pkg::*;
#(
    parameter int DataWidth = DATA_W,
    parameter int MaxLen    = MAX_LEN,
    parameter int SeqWidth  = SEQ_W
) (
    input  logic            clk_DA,
    input  logic            rst,
    cdc_frame_tx_if.master  bus
);
    localparam int LenW = $clog2(MaxLen + 1);

    tx_state_e            state_q, state_d;
    logic [LenW-1:0]      len_q, len_d;
    logic [LenW-1:0]      rem_q, rem_d;
    logic [DataWidth-1:0] sum_q, sum_d;
    logic [SeqWidth-1:0]  seq_q, seq_d;
    logic                 frame_done_q, frame_done_d;
    logic                 len_error_q, len_error_d;
    logic [DataWidth-1:0] header_w;

    assign header_w = DataWidth'(len_q) | (DataWidth'(seq_q) << LenW);

    always_ff @(posedge clk_DA or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            rem_q        <= '0;
            sum_q        <= '0;
            seq_q        <= '0;
            frame_done_q <= 1'b0;
            len_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            rem_q        <= rem_d;
            sum_q        <= sum_d;
            seq_q        <= seq_d;
            frame_done_q <= frame_done_d;
            len_error_q  <= len_error_d;
        end
    end

    // Each branch gates its register updates on the transfer condition of that
    // state so a stalled word leaves Sum/Remaining/Seq untouched.
    always_comb begin
        state_d           = state_q;
        len_d             = len_q;
        rem_d             = rem_q;
        sum_d             = sum_q;
        seq_d             = seq_q;
        frame_done_d      = 1'b0;
        len_error_d       = 1'b0;
        bus.StartReady_DA = 1'b0;
        bus.SrcReady_DA   = 1'b0;
        bus.Push_DA       = 1'b0;
        bus.DataIn_DA     = '0;

        unique case (state_q)
            ST_IDLE: begin
                bus.StartReady_DA = 1'b1;
                if (bus.Start_DA) begin
                    if (bus.Len_DA > LenW'(MaxLen)) begin
                        len_error_d = 1'b1;
                    end else begin
                        len_d   = bus.Len_DA;
                        rem_d   = bus.Len_DA;
                        sum_d   = '0;
                        state_d = ST_HEADER;
                    end
                end
            end
            ST_HEADER: begin
                bus.Push_DA   = 1'b1;
                bus.DataIn_DA = header_w;
                if (!bus.FifoFull_DA) begin
                    sum_d   = sum_q + header_w;
                    state_d = (len_q == '0) ? ST_CHECKSUM : ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                bus.Push_DA     = bus.SrcValid_DA;
                bus.DataIn_DA   = bus.SrcData_DA;
                bus.SrcReady_DA = !bus.FifoFull_DA;
                if (bus.SrcValid_DA && !bus.FifoFull_DA) begin
                    sum_d = sum_q + bus.SrcData_DA;
                    rem_d = rem_q - LenW'(1);
                    if (rem_q == LenW'(1)) begin
                        state_d = ST_CHECKSUM;
                    end
                end
            end
            ST_CHECKSUM: begin
                bus.Push_DA   = 1'b1;
                bus.DataIn_DA = '0 - sum_q;
                if (!bus.FifoFull_DA) begin
                    seq_d        = seq_q + SeqWidth'(1);
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.FrameDone_DA = frame_done_q;
    assign bus.LenError_DA  = len_error_q;

endmodule

// File: doc/cdc_frame_tx.md
# cdc_frame_tx

Domain-A frame transmitter that drives the write side of the cross-domain FIFO. It accepts a frame request (length) plus payload words from a local source and emits onto the FIFO push interface: one header word, the payload words, and one checksum word. It honours the FIFO full backpressure flag word by word. It is the producer end of the framed A→B channel; a matching deframer consumes frames in domain B.

## Interface
- DataWidth, 32, FIFO word width; must satisfy DataWidth ≥ LenW+SeqWidth.
- MaxLen, 16, maximum payload words per frame; LenW = $clog2(MaxLen+1).
- SeqWidth, 8, frame sequence counter width.

Ports:
- clk_DA  in  1  domain-A clock, all logic posedge.
- rst  in  1  reset, asynchronous, active-high.
- Start_DA  in  1  frame request; accepted when StartReady_DA=1.
- Len_DA  in  LenW  payload length for the request, 0..MaxLen.
- StartReady_DA  out  1  high only in IDLE.
- SrcValid_DA  in  1  payload word valid.
- SrcData_DA  in  DataWidth  payload word.
- SrcReady_DA  out  1  payload word consumed this cycle.
- Push_DA  out  1  to FIFO push.
- DataIn_DA  out  DataWidth  to FIFO data input.
- FifoFull_DA  in  1  from FIFO; a word transfers only when Push_DA & !FifoFull_DA.
- FrameDone_DA  out  1  one-cycle pulse after the checksum word is accepted.
- LenError_DA  out  1  one-cycle pulse when a request has Len_DA > MaxLen.

## Operation
- Xfer = Push_DA & !FifoFull_DA.
- FSM states: IDLE, HEADER, PAYLOAD, CHECKSUM.
- IDLE:
  - With Start_DA and Len_DA ≤ MaxLen, latch Len into Remaining, clear Sum, and go to HEADER.
  - With Start_DA and Len_DA > MaxLen, pulse LenError_DA next cycle and stay in IDLE; nothing is pushed.
- HEADER:
  - Push_DA=1; DataIn_DA = {zeros, Seq, Len}, with Len in bits [LenW-1:0] and Seq in the next SeqWidth bits.
  - On Xfer: Sum += header. Go to PAYLOAD if Len≠0, else CHECKSUM.
- PAYLOAD:
  - Push_DA = SrcValid_DA; DataIn_DA = SrcData_DA; SrcReady_DA = !FifoFull_DA.
  - On Xfer: Sum += word and Remaining−1. When Remaining==1, go to CHECKSUM.
- CHECKSUM:
  - Push_DA=1; DataIn_DA = −Sum (two's complement, mod 2^DataWidth), so the sum of all frame words is 0.
  - On Xfer: Seq += 1 (wraps at 2^SeqWidth), pulse FrameDone_DA next cycle, go to IDLE.
- Sum is a DataWidth-bit accumulator; carries are discarded.
- SrcReady_DA is 0 outside PAYLOAD. Push_DA is 0 in IDLE.
- FifoFull_DA held high: the state, DataIn_DA and Push_DA hold; Sum, Remaining and Seq do not change.

## Timing
- Reset values: StartReady_DA=1, Push_DA=0, DataIn_DA=0, SrcReady_DA=0, FrameDone_DA=0, LenError_DA=0, Seq=0, state IDLE.
- Reset is asserted asynchronously and deasserted synchronously.
- Reset mid-frame aborts the frame immediately. Push_DA drops with rst; the partial frame is not completed and Seq is not incremented.
- Push_DA, DataIn_DA and SrcReady_DA are combinational from state, registers, SrcValid_DA/SrcData_DA and FifoFull_DA. There is no registered stage in the push path.
- Start accepted in cycle 0 → header presented in cycle 1.
- Minimum frame time with no backpressure: Len+2 push cycles; the next Start is accepted in the cycle after the checksum Xfer.
- FrameDone_DA and LenError_DA are registered, one cycle wide.

## Structure
- Package cdc_frame_pkg holds:
  - the state enum;
  - the header field offsets (LenW, Seq position);
  - a pack_header/unpack_header function pair, shared with the domain-B deframer;
  - a checksum helper.
- No sub-module: single FSM plus accumulator. Integration with the FIFO is done in a separate wrapper, not inside this block.

## Test plan
All scenarios use DataWidth=32, SeqWidth=8, MaxLen=16 (LenW=5), FifoFull_DA=0 unless stated.
- Start, Len=3, payload 1,2,3 → pushes 0x00000003, 1, 2, 3, 0xFFFFFFF7 on consecutive cycles; FrameDone_DA one cycle after the last push. A second identical frame then has header 0x00000023 and checksum 0xFFFFFFD7.
- Len=0 after reset → pushes 0x00000000, then 0x00000000; Seq becomes 1.
- Len=17 → LenError_DA pulses once, Push_DA never rises, StartReady_DA stays 1.
- Len=2, FifoFull_DA held high for 3 cycles on the first payload word → SrcReady_DA=0 and DataIn_DA stable for those cycles; the frame completes with the correct checksum and no duplicated or dropped words.
- rst pulsed mid-payload → Push_DA=0 immediately. The next frame uses Seq 0, and its checksum excludes the aborted words.
- 256 frames of Len=1 → header Seq field goes 0xFF then 0x00; each frame's words sum to 0 mod 2^32.
